sprite_animator: RTL and testbench
==================================

// Module: sprite_animator
// PURPOSE
//  Drives the player sprite's screen position and sprite-sheet cell.
//  Sits directly upstream of color_mapper and feeds its shape_x, shape_y and sel inputs.
//  Samples the keyboard keycode once per video frame, moves the 32x52 sprite with edge
//  limiting, and steps a 4-frame walk cycle from a 4x4 sheet.
//  sel = {dir[1:0], frame[1:0]}.
// PARAMETERS
//  X_START   304  reset X of sprite top-left, in pixels
//  Y_START   214  reset Y of sprite top-left, in pixels
//  STEP      2    pixels moved per frame tick
//  ANIM_DIV  8    frame ticks per walk-cycle step (>=1)
//  SPRITE_W  32   sprite width in pixels
//  SPRITE_H  52   sprite height in pixels
//  SCREEN_W  640  visible width in pixels
//  SCREEN_H  480  visible height in pixels
// PORTS
//  Clk        in   1   system clock
//  Reset_n    in   1   asynchronous, active-low reset
//  frame_clk  in   1   vertical-sync-rate strobe, asynchronous to Clk
//  keycode    in   8   current key: 0x1A W/up, 0x04 A/left, 0x16 S/down, 0x07 D/right; other = none
//  shape_x    out  10  sprite top-left X, to color_mapper
//  shape_y    out  10  sprite top-left Y, to color_mapper
//  sel        out  4   sheet cell: {dir, frame}; dir 00 down, 01 left, 10 right, 11 up
//  moving     out  1   high while the state is WALK
// BEHAVIOUR
//  - Reset (async, Reset_n=0): shape_x=X_START, shape_y=Y_START, dir=00, frame=0, sel=0,
//    anim_cnt=0, moving=0, state=IDLE, sync flops=0. Outputs change immediately, with no clock needed.
//  - frame_clk passes through a 2-flop synchronizer. The rising edge of the synced signal gives a
//    1-Clk `tick`. Outputs update on the Clk edge after tick: 4 Clk edges after the frame_clk rise.
//  - All state changes occur only on tick. Outputs are registered and stable between ticks, so
//    color_mapper sees constant values for a whole frame.
//  - keycode is sampled only on tick. Changes between ticks are ignored.
//  - FSM states: IDLE, WALK.
//    IDLE + tick + direction key:
//      dir <= key direction; move one STEP; frame=0; anim_cnt=0; go to WALK.
//    IDLE + tick + no direction key: hold everything.
//    WALK + tick + same direction:
//      move one STEP.
//      anim_cnt++. When anim_cnt==ANIM_DIV-1: anim_cnt=0 and frame=frame+1 mod 4 (3->0 wraps).
//    WALK + tick + different direction:
//      dir updated; move one STEP; frame=0; anim_cnt=0; stay in WALK.
//    WALK + tick + no direction key:
//      go to IDLE; frame=0; anim_cnt=0; position held; dir held.
//  - Movement arithmetic: done in 11 bits, so no 10-bit wrap artefacts.
//    X_MAX = SCREEN_W-SPRITE_W (608). Y_MAX = SCREEN_H-SPRITE_H (428).
//    left:  x = (x>=STEP) ? x-STEP : 0
//    right: x = min(x+STEP, X_MAX)
//    up/down: same rule applied to y against Y_MAX.
//  - At a limit, animation continues (walking into a wall). moving stays 1.
//  - Reset asserted mid-walk aborts everything. Release is synchronous to the next Clk edge; the
//    first tick after release is handled from IDLE.
//  - Invariant: the sprite rectangle always lies fully on screen (x<=608, y<=428).
// CONFIGURATION
//  SPRITE_WRAP_EN defined:
//    Leaving an edge wraps to the opposite limit.
//    left from x<STEP -> X_MAX; right past X_MAX -> 0; same for y.
//  SPRITE_WRAP_EN undefined (default): clamp as described in BEHAVIOUR.
//  Timing, FSM and animation are identical in both builds.
// TESTING
//  1. Reset: Reset_n=0, no Clk.
//     -> shape_x=304, shape_y=214, sel=0, moving=0 immediately.
//  2. keycode=0x07 held for 9 frame_clk pulses.
//     -> shape_x=322, shape_y=214, sel=4'b1001, moving=1.
//     Outputs are constant between pulses.
//  3. keycode=0x07 toggled with frame_clk static for 100 Clk.
//     -> no output change.
//  4. Start at x=606, keycode=0x07, 3 pulses.
//     -> shape_x=608 and held; sel column keeps advancing per ANIM_DIV.
//  5. Walking right, then keycode=0x00 on 1 pulse.
//     -> moving=0, sel=4'b1000, position unchanged.
//     Then keycode=0x1A, 1 pulse -> sel=4'b1100, y-=2.
//  6. x=0, keycode=0x04, 1 pulse.
//     -> shape_x=0 (default build); shape_x=608 with SPRITE_WRAP_EN.
//     Then Reset_n low mid-walk -> reset values asynchronously.

Source files
------------

// File: rtl/sprite_animator.sv
// Player sprite position and walk-cycle animator, stepping once per synchronized frame_clk tick.
// Optional build macro SPRITE_WRAP_EN: wrap to the opposite limit instead of clamping at edges.
module sprite_animator #(
  parameter int X_START  = 304,
  parameter int Y_START  = 214,
  parameter int STEP     = 2,
  parameter int ANIM_DIV = 8,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 52,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] shape_x,
  output logic [9:0] shape_y,
  output logic [3:0] sel,
  output logic       moving
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [CW-1:0] ANIM_LAST = CW'(ANIM_DIV - 1);

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic {IDLE, WALK} state_t;

  state_t        state, state_next;
  logic [1:0]    dir, dir_next;
  logic [1:0]    frame, frame_next;
  logic [CW-1:0] anim_cnt, anim_cnt_next;
  logic [9:0]    pos_x, pos_x_next;
  logic [9:0]    pos_y, pos_y_next;

  logic sync_a, sync_b, sync_prev, tick;
  logic       key_valid;
  logic [1:0] key_dir;
  logic [10:0] x_ext, y_ext;
  logic [10:0] x_dec, x_inc, y_dec, y_inc;
  logic [9:0]  moved_x, moved_y;

  // frame_clk is asynchronous: two flops, then a registered rising-edge detect gives a 1-Clk tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      sync_prev <= 1'b0;
      tick      <= 1'b0;
    end else begin
      sync_a    <= frame_clk;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      tick      <= sync_b & ~sync_prev;
    end
  end

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_DOWN;
    case (keycode)
      KEY_UP:    key_dir = DIR_UP;
      KEY_LEFT:  key_dir = DIR_LEFT;
      KEY_DOWN:  key_dir = DIR_DOWN;
      KEY_RIGHT: key_dir = DIR_RIGHT;
      default:   key_valid = 1'b0;
    endcase
  end

  // Candidate positions are computed in 11 bits so that neither edge can alias through a 10-bit wrap
  always_comb begin
    x_ext = {1'b0, pos_x};
    y_ext = {1'b0, pos_y};
`ifdef SPRITE_WRAP_EN
    x_dec = (x_ext >= STEP11) ? x_ext - STEP11 : X_MAX;
    y_dec = (y_ext >= STEP11) ? y_ext - STEP11 : Y_MAX;
    x_inc = (x_ext + STEP11 > X_MAX) ? 11'd0 : x_ext + STEP11;
    y_inc = (y_ext + STEP11 > Y_MAX) ? 11'd0 : y_ext + STEP11;
`else
    x_dec = (x_ext >= STEP11) ? x_ext - STEP11 : 11'd0;
    y_dec = (y_ext >= STEP11) ? y_ext - STEP11 : 11'd0;
    x_inc = (x_ext + STEP11 > X_MAX) ? X_MAX : x_ext + STEP11;
    y_inc = (y_ext + STEP11 > Y_MAX) ? Y_MAX : y_ext + STEP11;
`endif
    moved_x = pos_x;
    moved_y = pos_y;
    case (key_dir)
      DIR_DOWN:  moved_y = y_inc[9:0];
      DIR_LEFT:  moved_x = x_dec[9:0];
      DIR_RIGHT: moved_x = x_inc[9:0];
      default:   moved_y = y_dec[9:0];
    endcase
  end

  always_comb begin
    state_next    = state;
    dir_next      = dir;
    frame_next    = frame;
    anim_cnt_next = anim_cnt;
    pos_x_next    = pos_x;
    pos_y_next    = pos_y;
    if (tick) begin
      if (!key_valid) begin
        state_next    = IDLE;
        frame_next    = 2'd0;
        anim_cnt_next = '0;
      end else begin
        pos_x_next = moved_x;
        pos_y_next = moved_y;
        state_next = WALK;
        if (state == WALK && key_dir == dir) begin
          if (anim_cnt == ANIM_LAST) begin
            anim_cnt_next = '0;
            frame_next    = frame + 2'd1;
          end else begin
            anim_cnt_next = anim_cnt + CW'(1);
          end
        end else begin
          dir_next      = key_dir;
          frame_next    = 2'd0;
          anim_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      dir      <= DIR_DOWN;
      frame    <= 2'd0;
      anim_cnt <= '0;
      pos_x    <= 10'(X_START);
      pos_y    <= 10'(Y_START);
    end else begin
      state    <= state_next;
      dir      <= dir_next;
      frame    <= frame_next;
      anim_cnt <= anim_cnt_next;
      pos_x    <= pos_x_next;
      pos_y    <= pos_y_next;
    end
  end

  assign shape_x = pos_x;
  assign shape_y = pos_y;
  assign sel     = {dir, frame};
  assign moving  = (state == WALK);

endmodule

// File: tb/tb_sprite_animator.sv
// Scoreboard bench for sprite_animator: a behavioural model queues expected outputs per frame pulse.
// Honours SPRITE_WRAP_EN the same way as the design build.
module tb_sprite_animator;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] shape_x, shape_y;
  logic [3:0] sel;
  logic       moving;

  typedef struct {
    int x;
    int y;
    int sel;
    int moving;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  int m_x, m_y, m_dir, m_frame, m_anim, m_walk;

  sprite_animator dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .shape_x(shape_x), .shape_y(shape_y), .sel(sel), .moving(moving)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_x = 304; m_y = 214; m_dir = 0; m_frame = 0; m_anim = 0; m_walk = 0;
  endtask

  function automatic int key_to_dir(input logic [7:0] k);
    case (k)
      8'h16: return 0;
      8'h04: return 1;
      8'h07: return 2;
      8'h1A: return 3;
      default: return -1;
    endcase
  endfunction

  // One frame tick of the reference behaviour
  task automatic model_tick(input logic [7:0] k);
    int d;
    d = key_to_dir(k);
    if (d < 0) begin
      m_walk = 0; m_frame = 0; m_anim = 0;
    end else begin
      if (m_walk == 1 && d == m_dir) begin
        if (m_anim == 7) begin m_anim = 0; m_frame = (m_frame + 1) % 4; end
        else m_anim = m_anim + 1;
      end else begin
        m_dir = d; m_frame = 0; m_anim = 0; m_walk = 1;
      end
`ifdef SPRITE_WRAP_EN
      case (d)
        0: m_y = (m_y + 2 > 428) ? 0 : m_y + 2;
        1: m_x = (m_x < 2) ? 608 : m_x - 2;
        2: m_x = (m_x + 2 > 608) ? 0 : m_x + 2;
        default: m_y = (m_y < 2) ? 428 : m_y - 2;
      endcase
`else
      case (d)
        0: m_y = (m_y + 2 > 428) ? 428 : m_y + 2;
        1: m_x = (m_x < 2) ? 0 : m_x - 2;
        2: m_x = (m_x + 2 > 608) ? 608 : m_x + 2;
        default: m_y = (m_y < 2) ? 0 : m_y - 2;
      endcase
`endif
    end
  endtask

  task automatic compare_now(input string tag);
    checkOutput({tag, "_x"}, int'(shape_x), m_x);
    checkOutput({tag, "_y"}, int'(shape_y), m_y);
    checkOutput({tag, "_sel"}, int'(sel), m_dir * 4 + m_frame);
    checkOutput({tag, "_moving"}, int'(moving), m_walk);
  endtask

  // Drive one frame_clk pulse with a key held, queue the expected result, then score it
  task automatic applyStimulus(input logic [7:0] k);
    exp_t e, got;
    @(negedge Clk);
    keycode = k;
    frame_clk = 1'b1;
    model_tick(k);
    e.x = m_x; e.y = m_y; e.sel = m_dir * 4 + m_frame; e.moving = m_walk;
    exp_q.push_back(e);
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    if (exp_q.size() == 0) begin
      checkOutput("queue_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      checkOutput("pulse_x", int'(shape_x), got.x);
      checkOutput("pulse_y", int'(shape_y), got.y);
      checkOutput("pulse_sel", int'(sel), got.sel);
      checkOutput("pulse_moving", int'(moving), got.moving);
    end
  endtask

  initial begin
    model_reset();
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("reset_x", int'(shape_x), 304);
    checkOutput("reset_y", int'(shape_y), 214);
    checkOutput("reset_sel", int'(sel), 0);
    checkOutput("reset_moving", int'(moving), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 9; i++) applyStimulus(8'h07);
    checkOutput("walk9_x", int'(shape_x), 322);
    checkOutput("walk9_sel", int'(sel), 4'b1001);
    checkOutput("walk9_moving", int'(moving), 1);

    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      keycode = (i % 2 == 0) ? 8'h04 : 8'h07;
    end
    compare_now("no_tick");

    for (int i = 0; i < 142; i++) applyStimulus(8'h07);
    checkOutput("at_606", int'(shape_x), 606);
    for (int i = 0; i < 3; i++) applyStimulus(8'h07);
`ifndef SPRITE_WRAP_EN
    checkOutput("right_clamp", int'(shape_x), 608);
`endif

    applyStimulus(8'h00);
    checkOutput("stop_moving", int'(moving), 0);
    checkOutput("stop_sel", int'(sel), 4'b1000);
    applyStimulus(8'h1A);
    checkOutput("up_sel", int'(sel), 4'b1100);
    checkOutput("up_y", int'(shape_y), 212);

    while (m_x > 0) applyStimulus(8'h04);
    checkOutput("at_0", int'(shape_x), 0);
    applyStimulus(8'h04);
`ifdef SPRITE_WRAP_EN
    checkOutput("left_edge", int'(shape_x), 608);
`else
    checkOutput("left_edge", int'(shape_x), 0);
`endif

    applyStimulus(8'h04);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    model_reset();
    #1;
    compare_now("mid_reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(8'h16);
    checkOutput("post_reset_y", int'(shape_y), 216);
    checkOutput("post_reset_sel", int'(sel), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
